boundary_scan_register: RTL and testbench

BOUNDARY_SCAN_REGISTER -- requirements
Module: boundary_scan_register

---
 rtl/boundary_scan_register.sv | 85 ++++++++
 tb/tb_boundary_scan_register.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/boundary_scan_register.sv
// Boundary-scan register: 8-bit capture/shift chain (bsr) with a parallel
// update latch (upd). Cells [3:0] sit between device pins and core inputs,
// cells [7:4] between core outputs and device pins; bit 0 feeds TDO.
// Optional feature macro: BSR_BYPASS_EN adds a 1-bit bypass register that is
// selected by the BYPASS instruction. Without it, BYPASS behaves as SAMPLE.
module boundary_scan_register (
  input  logic       TCK,
  input  logic       TRST,
  input  logic       TDI,
  output logic       TDO,
  input  logic       capture_dr,
  input  logic       shift_dr,
  input  logic       update_dr,
  input  logic [1:0] instr,
  input  logic [3:0] pin_in,
  output logic [3:0] core_in,
  input  logic [3:0] core_out,
  output logic [3:0] pin_out
);

  typedef enum logic [1:0] {
    INSTR_BYPASS = 2'b00,
    INSTR_SAMPLE = 2'b01,
    INSTR_EXTEST = 2'b10,
    INSTR_INTEST = 2'b11
  } instr_e;

  instr_e     op;
  logic       bsr_sel;
  logic [7:0] bsr;
  logic [7:0] upd;

  assign op = instr_e'(instr);

`ifdef BSR_BYPASS_EN
  logic byp;

  assign bsr_sel = (op != INSTR_BYPASS);

  // Bypass bit: captures 0, shifts TDI; only active while BYPASS is selected
  always_ff @(posedge TCK) begin
    if (TRST) begin
      byp <= 1'b0;
    end else if (!bsr_sel) begin
      if (capture_dr) begin
        byp <= 1'b0;
      end else if (shift_dr) begin
        byp <= TDI;
      end
    end
  end
`else
  assign bsr_sel = 1'b1;
`endif

  // Scan chain and update latch; capture beats shift beats update
  always_ff @(posedge TCK) begin
    if (TRST) begin
      bsr <= '0;
      upd <= '0;
    end else if (capture_dr) begin
      if (bsr_sel) begin
        bsr <= {core_out, pin_in};
      end
    end else if (shift_dr) begin
      if (bsr_sel) begin
        bsr <= {TDI, bsr[7:1]};
      end
    end else if (update_dr) begin
      upd <= bsr;
    end
  end

  // Serial output and pin/core muxes, all combinational on instr
  always_comb begin
`ifdef BSR_BYPASS_EN
    TDO = bsr_sel ? bsr[0] : byp;
`else
    TDO = bsr[0];
`endif
    core_in = (op == INSTR_INTEST) ? upd[3:0] : pin_in;
    pin_out = (op == INSTR_EXTEST) ? upd[7:4] : core_out;
  end

endmodule

// File: tb/tb_boundary_scan_register.sv
// Self-checking bench for boundary_scan_register: directed scenarios plus a
// randomized run compared against a behavioural model of the scan cells.
module tb_boundary_scan_register;

  logic       TCK = 1'b0;
  logic       TRST = 1'b1;
  logic       TDI = 1'b0;
  logic       TDO;
  logic       capture_dr = 1'b0;
  logic       shift_dr = 1'b0;
  logic       update_dr = 1'b0;
  logic [1:0] instr = 2'b01;
  logic [3:0] pin_in = 4'h0;
  logic [3:0] core_in;
  logic [3:0] core_out = 4'h0;
  logic [3:0] pin_out;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Behavioural model state
  logic [7:0] m_bsr = 8'h00;
  logic [7:0] m_upd = 8'h00;
  logic       m_byp = 1'b0;

  boundary_scan_register dut (
    .TCK       (TCK),
    .TRST      (TRST),
    .TDI       (TDI),
    .TDO       (TDO),
    .capture_dr(capture_dr),
    .shift_dr  (shift_dr),
    .update_dr (update_dr),
    .instr     (instr),
    .pin_in    (pin_in),
    .core_in   (core_in),
    .core_out  (core_out),
    .pin_out   (pin_out)
  );

  always #5 TCK = ~TCK;

  function automatic bit chain_is_bsr(input logic [1:0] ins);
`ifdef BSR_BYPASS_EN
    return ins != 2'b00;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic exp_tdo();
    return chain_is_bsr(instr) ? m_bsr[0] : m_byp;
  endfunction

  function automatic logic [3:0] exp_core_in();
    return (instr == 2'b11) ? m_upd[3:0] : pin_in;
  endfunction

  function automatic logic [3:0] exp_pin_out();
    return (instr == 2'b10) ? m_upd[7:4] : core_out;
  endfunction

  // One TCK: model computes the next state from the current inputs, then the
  // bench waits for the edge and settles 1 time unit past it.
  task automatic clk_cycle();
    logic [7:0] n_bsr = m_bsr;
    logic [7:0] n_upd = m_upd;
    logic       n_byp = m_byp;
    if (TRST) begin
      n_bsr = 8'h00; n_upd = 8'h00; n_byp = 1'b0;
    end else if (capture_dr) begin
      if (chain_is_bsr(instr)) n_bsr = {core_out, pin_in};
      else n_byp = 1'b0;
    end else if (shift_dr) begin
      if (chain_is_bsr(instr)) n_bsr = (m_bsr / 2) + (TDI ? 8'd128 : 8'd0);
      else n_byp = TDI;
    end else if (update_dr) begin
      n_upd = m_bsr;
    end
    @(posedge TCK);
    m_bsr = n_bsr; m_upd = n_upd; m_byp = n_byp;
    #1;
  endtask

  // Shift a byte in LSB-first while collecting the byte that comes out on TDO
  task automatic shift_byte(input logic [7:0] din, output logic [7:0] dout);
    for (int i = 0; i < 8; i++) begin
      dout[i] = TDO;
      TDI = din[i];
      shift_dr = 1'b1;
      clk_cycle();
    end
    shift_dr = 1'b0;
    TDI = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] got;
    instr = 2'b01; pin_in = 4'h6; core_out = 4'h9; TRST = 1'b1;
    clk_cycle();
    TRST = 1'b0;
    total_cnt++; if (TDO !== 1'b0) $display("FAIL reset_tdo got=%b exp=0", TDO); else pass_cnt++;
    total_cnt++; if (core_in !== 4'h6) $display("FAIL reset_core_in got=%h exp=6", core_in); else pass_cnt++;
    total_cnt++; if (pin_out !== 4'h9) $display("FAIL reset_pin_out got=%h exp=9", pin_out); else pass_cnt++;
    instr = 2'b11; #1;
    total_cnt++; if (core_in !== 4'h0) $display("FAIL reset_upd_lo got=%h exp=0", core_in); else pass_cnt++;
    instr = 2'b10; #1;
    total_cnt++; if (pin_out !== 4'h0) $display("FAIL reset_upd_hi got=%h exp=0", pin_out); else pass_cnt++;
    instr = 2'b01; #1;
    shift_byte(8'h00, got);
    total_cnt++; if (got !== 8'h00) $display("FAIL reset_bsr got=%h exp=00", got); else pass_cnt++;
  endtask

  task automatic test_sample();
    logic [7:0] seq = 8'h3A;
    instr = 2'b01; pin_in = 4'hA; core_out = 4'h3; capture_dr = 1'b1;
    clk_cycle();
    capture_dr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total_cnt++;
      if (TDO !== seq[i]) $display("FAIL sample_tdo bit%0d got=%b exp=%b", i, TDO, seq[i]);
      else pass_cnt++;
      TDI = 1'b0; shift_dr = 1'b1;
      clk_cycle();
    end
    shift_dr = 1'b0;
  endtask

  task automatic test_extest();
    logic [7:0] got;
    instr = 2'b10; pin_in = 4'h2; core_out = 4'h7;
    shift_byte(8'hC5, got);
    update_dr = 1'b1;
    clk_cycle();
    update_dr = 1'b0;
    total_cnt++; if (pin_out !== 4'hC) $display("FAIL extest_pin_out got=%h exp=c", pin_out); else pass_cnt++;
    total_cnt++; if (core_in !== 4'h2) $display("FAIL extest_core_in got=%h exp=2", core_in); else pass_cnt++;
    instr = 2'b01; #1;
    total_cnt++; if (pin_out !== 4'h7) $display("FAIL extest_release got=%h exp=7", pin_out); else pass_cnt++;
  endtask

  task automatic test_intest();
    logic [7:0] got;
    instr = 2'b11; pin_in = 4'h4; core_out = 4'h1;
    shift_byte(8'h09, got);
    update_dr = 1'b1;
    clk_cycle();
    update_dr = 1'b0;
    total_cnt++; if (core_in !== 4'h9) $display("FAIL intest_core_in got=%h exp=9", core_in); else pass_cnt++;
    total_cnt++; if (pin_out !== 4'h1) $display("FAIL intest_pin_out got=%h exp=1", pin_out); else pass_cnt++;
    core_out = 4'h8; capture_dr = 1'b1;
    clk_cycle();
    capture_dr = 1'b0;
    shift_byte(8'h00, got);
    total_cnt++; if (got !== 8'h84) $display("FAIL intest_capture got=%h exp=84", got); else pass_cnt++;
    total_cnt++; if (core_in !== 4'h9) $display("FAIL intest_upd_hold got=%h exp=9", core_in); else pass_cnt++;
  endtask

  task automatic test_priority();
    logic [7:0] got;
    instr = 2'b01; pin_in = 4'h5; core_out = 4'h6;
    capture_dr = 1'b1; shift_dr = 1'b1; TDI = 1'b1;
    clk_cycle();
    capture_dr = 1'b0; shift_dr = 1'b0; TDI = 1'b0;
    shift_byte(8'hE7, got);
    total_cnt++; if (got !== 8'h65) $display("FAIL prio_capture_shift got=%h exp=65", got); else pass_cnt++;
    shift_dr = 1'b1; update_dr = 1'b1; TDI = 1'b0;
    clk_cycle();
    shift_dr = 1'b0;
    instr = 2'b10;
    clk_cycle();
    update_dr = 1'b0;
    total_cnt++; if (pin_out !== 4'h7) $display("FAIL prio_shift_update got=%h exp=7", pin_out); else pass_cnt++;
    TRST = 1'b1; update_dr = 1'b1;
    clk_cycle();
    TRST = 1'b0; update_dr = 1'b0;
    total_cnt++; if (pin_out !== 4'h0) $display("FAIL prio_trst_update got=%h exp=0", pin_out); else pass_cnt++;
  endtask

  task automatic test_instr00();
    logic [7:0] got;
    logic [2:0] pat = 3'b101;
    logic [2:0] exp_seq;
    instr = 2'b01; pin_in = 4'hA; core_out = 4'h3; capture_dr = 1'b1;
    clk_cycle();
    instr = 2'b00; pin_in = 4'hF; core_out = 4'hF;
    clk_cycle();
    capture_dr = 1'b0;
`ifdef BSR_BYPASS_EN
    exp_seq = 3'b010;
`else
    exp_seq = 3'b111;
`endif
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (TDO !== exp_seq[2-i]) $display("FAIL instr00_tdo step%0d got=%b exp=%b", i, TDO, exp_seq[2-i]);
      else pass_cnt++;
      TDI = pat[2-i]; shift_dr = 1'b1;
      clk_cycle();
    end
    shift_dr = 1'b0;
    instr = 2'b01; #1;
    shift_byte(8'h00, got);
`ifdef BSR_BYPASS_EN
    total_cnt++; if (got !== 8'h3A) $display("FAIL instr00_bsr_hold got=%h exp=3a", got); else pass_cnt++;
`else
    total_cnt++; if (got !== 8'hBF) $display("FAIL instr00_as_sample got=%h exp=bf", got); else pass_cnt++;
`endif
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      TRST       = ($urandom_range(0, 31) == 0);
      capture_dr = ($urandom_range(0, 5) == 0);
      shift_dr   = ($urandom_range(0, 1) == 1);
      update_dr  = ($urandom_range(0, 4) == 0);
      TDI        = 1'($urandom);
      pin_in     = 4'($urandom);
      core_out   = 4'($urandom);
      if ($urandom_range(0, 7) == 0) instr = 2'($urandom);
      #1;
      total_cnt++;
      if (TDO !== exp_tdo() || core_in !== exp_core_in() || pin_out !== exp_pin_out()) begin
        $display("FAIL random cyc%0d tdo/core_in/pin_out got=%b/%h/%h exp=%b/%h/%h",
                 n, TDO, core_in, pin_out, exp_tdo(), exp_core_in(), exp_pin_out());
      end else pass_cnt++;
      clk_cycle();
    end
    TRST = 1'b0; capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sample();
    test_extest();
    test_intest();
    test_priority();
    test_instr00();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached passed=%0d total=%0d", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule
